// File: rtl/spi_les_pkg.sv
// Shared definitions for the SPI master sequencer: FSM state encoding and
// default frame/clock-divider settings.
package spi_les_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_CLK_DIV = 2;

endpackage

// File: rtl/spi_master_ctrl_shift_register.sv
// MSB-first parallel-load shift register; the MSB drives the serial output and
// the serial input enters at bit 0. A parallel load wins over a shift.
module shift_register #(
    parameter int WIDTH = spi_les_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_enable,
    input  logic             shift_in,
    output logic [WIDTH-1:0] data_out,
    output logic             shift_out
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] chain;

    // chain[gi] is the value bit gi takes on a shift
    generate
        if (WIDTH == 1) begin : g_chain_one
            assign chain = shift_in;
        end else begin : g_chain_many
            assign chain = {data_reg[WIDTH-2:0], shift_in};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign data_next[gi] = data_enable  ? data_in[gi] :
                                   shift_enable ? chain[gi]   : data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
        end else begin
            data_reg <= data_next;
        end
    end

    assign data_out  = data_reg;
    assign shift_out = data_reg[WIDTH-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: accepts a word on a valid/ready port, clocks it out MSB
// first while capturing miso, and returns the received word as a one-cycle pulse.
module spi_master_ctrl
    import spi_les_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             cs_n,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic             cs_n_reg, sclk_reg;
    logic             data_enable, shift_enable;
    logic             phase_end;

    shift_register #(.WIDTH(WIDTH)) u_shift (
        .clk          (clk),
        .rst          (~rst_n),
        .data_enable  (data_enable),
        .data_in      (tx_data),
        .shift_enable (shift_enable),
        .shift_in     (miso),
        .data_out     (rx_data),
        .shift_out    (mosi)
    );

    assign phase_end = (div_cnt_reg == DIV_LAST);

    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        data_enable  = 1'b0;
        shift_enable = 1'b0;
        tx_ready     = 1'b0;
        rx_valid     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    data_enable  = 1'b1;
                    state_next   = SETUP;
                    div_cnt_next = '0;
                    bit_cnt_next = '0;
                end
            end
            SETUP, LOW, HOLD: begin
                if (phase_end) begin
                    div_cnt_next = '0;
                    state_next   = (state_reg == HOLD) ? DONE : HIGH;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            HIGH: begin
                // last high cycle: sample miso and shift on the falling edge
                if (phase_end) begin
                    shift_enable = 1'b1;
                    div_cnt_next = '0;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    state_next   = (bit_cnt_reg == BIT_LAST) ? HOLD : LOW;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                rx_valid   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            cs_n_reg    <= 1'b1;
            sclk_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            // pin levels follow the state being entered so they are registered
            cs_n_reg    <= (state_next == IDLE) || (state_next == DONE);
            sclk_reg    <= (state_next == HIGH);
        end
    end

    assign cs_n = cs_n_reg;
    assign sclk = sclk_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomized self-checking bench for spi_master_ctrl: a frame-level slave/monitor
// model predicts received words, cs_n timing, sclk pulse count and mosi bits.
module tb_spi_master_ctrl;

    localparam int W  = 8;
    localparam int CD = 2;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slave;
        bit         loop;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid, tx_ready, rx_valid, busy, cs_n, sclk, mosi, miso;
    logic [7:0] tx_data, rx_data;

    logic       tx_valid1, tx_ready1, rx_valid1, busy1, cs_n1, sclk1, mosi1, miso1;
    logic [0:0] tx_data1, rx_data1;

    always #5 clk = ~clk;

    spi_master_ctrl #(.WIDTH(W), .CLK_DIV(CD)) u_dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    spi_master_ctrl #(.WIDTH(1), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .tx_data(tx_data1), .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1),
        .cs_n(cs_n1), .sclk(sclk1), .mosi(mosi1), .miso(miso1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- frame-level slave + monitor model ----------------
    frame_t     exp_q[$];
    logic [7:0] rx_q[$];
    int         low_q[$], rise_q[$], err_q[$], gap_q[$];
    logic       vrise_q[$];
    frame_t     cur = '{tx: 8'h00, slave: 8'h00, loop: 1'b0};
    logic       cs_prev = 1'b1, sclk_prev = 1'b0;
    int         low_cnt = 0, hi_cnt = 0, rise_cnt = 0, fall_cnt = 0, mosi_err = 0;

    always @(negedge clk) begin
        if (cs_prev && !cs_n) begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            gap_q.push_back(hi_cnt);
            low_cnt = 0; rise_cnt = 0; fall_cnt = 0; mosi_err = 0;
        end
        if (!cs_prev && cs_n) begin
            low_q.push_back(low_cnt);
            rise_q.push_back(rise_cnt);
            err_q.push_back(mosi_err);
            vrise_q.push_back(rx_valid);
            hi_cnt = 0;
        end
        if (cs_n) hi_cnt++; else low_cnt++;
        if (sclk && !sclk_prev) rise_cnt++;
        if (!sclk && sclk_prev) fall_cnt++;
        if (sclk && !cs_n && rise_cnt >= 1 && rise_cnt <= W && mosi !== cur.tx[W - rise_cnt])
            mosi_err++;
        if (rx_valid) rx_q.push_back(rx_data);
        miso = cur.loop ? mosi : ((fall_cnt < W) ? cur.slave[W - 1 - fall_cnt] : 1'b0);
        cs_prev   = cs_n;
        sclk_prev = sclk;
    end

    task automatic clear_model();
        rx_q.delete(); low_q.delete(); rise_q.delete(); err_q.delete();
        gap_q.delete(); vrise_q.delete(); exp_q.delete();
    endtask

    task automatic start(input logic [7:0] tx, input logic [7:0] slave, input bit loop);
        int t = 0;
        exp_q.push_back('{tx: tx, slave: slave, loop: loop});
        @(negedge clk);
        tx_data  = tx;
        tx_valid = 1'b1;
        while (!tx_ready && t < 200) begin @(negedge clk); t++; end
        check("accept_timeout", 32'(t < 200), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rx_q.size() < n && t < 2000) begin @(posedge clk); t++; end
        check("rx_timeout", 32'(rx_q.size() >= n), 32'd1);
    endtask

    // checks one completed frame against the model's prediction
    task automatic check_frame(input string tag, input logic [7:0] exp_rx);
        if (rx_q.size() > 0 && low_q.size() > 0) begin
            check({tag, "_rx"},    32'(rx_q.pop_front()), 32'(exp_rx));
            check({tag, "_cslow"}, 32'(low_q.pop_front()), 32'((2 * W + 1) * CD));
            check({tag, "_rises"}, 32'(rise_q.pop_front()), 32'(W));
            check({tag, "_mosi"},  32'(err_q.pop_front()), 32'd0);
            check({tag, "_vrise"}, 32'(vrise_q.pop_front()), 32'd1);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] tx,
                             input logic [7:0] slave, input bit loop);
        start(tx, slave, loop);
        wait_rx(1);
        check_frame(tag, loop ? tx : slave);
    endtask

    initial begin
        logic [7:0] a, b;
        bit         lp;
        int         t;
        int         lo1, ri1;
        logic       rx1_seen;
        logic [0:0] rx1_val;
        logic       sprev1;

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; miso = 1'b0;
        tx_valid1 = 1'b0; tx_data1 = 1'b0; miso1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rxv",  32'(rx_valid), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_rxd",  32'(rx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(tx_ready), 32'd1);
        clear_model();

        run_frame("loop_a5", 8'hA5, 8'h00, 1'b1);
        $display("frame loopback tx=a5");
        run_frame("slave_3c", 8'hFF, 8'h3C, 1'b0);
        $display("frame slave tx=ff slave=3c");

        // back-to-back with tx_valid held high across both accepts
        clear_model();
        exp_q.push_back('{tx: 8'h01, slave: 8'h00, loop: 1'b1});
        exp_q.push_back('{tx: 8'h80, slave: 8'h00, loop: 1'b1});
        @(negedge clk);
        tx_data = 8'h01; tx_valid = 1'b1;
        t = 0;
        while (!tx_ready && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        tx_data = 8'h80;
        t = 0;
        while (!tx_ready && t < 200) begin @(negedge clk); t++; end
        check("b2b_accept", 32'(t < 200), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_rx(2);
        if (gap_q.size() >= 2) check("b2b_gap", 32'(gap_q[1]), 32'd2);
        check_frame("b2b_1", 8'h01);
        check_frame("b2b_2", 8'h80);
        $display("frame back-to-back 01 then 80");

        // tx_valid pulse while busy must be ignored
        clear_model();
        a = 8'($urandom); b = 8'($urandom);
        start(a, b, 1'b0);
        repeat (10) @(negedge clk);
        check("mid_ready", 32'(tx_ready), 32'd0);
        tx_data = ~a; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_rx(1);
        check_frame("mid", b);
        repeat (10) @(negedge clk);
        check("mid_nonew_busy", 32'(busy), 32'd0);
        check("mid_nonew_cs",   32'(cs_n), 32'd1);
        check("mid_nonew_rx",   32'(rx_q.size()), 32'd0);
        $display("frame mid-transfer pulse tx=%0h slave=%0h", a, b);

        // reset during the 4th high phase
        clear_model();
        exp_q.push_back('{tx: 8'h5A, slave: 8'hC3, loop: 1'b0});
        @(negedge clk);
        tx_data = 8'h5A; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        t = 0;
        while (rise_cnt != 4 && t < 500) begin @(posedge clk); t++; end
        check("rst4_reach", 32'(t < 500), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst4_cs_n", 32'(cs_n), 32'd1);
        check("rst4_sclk", 32'(sclk), 32'd0);
        check("rst4_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst4_norx", 32'(rx_q.size()), 32'd0);
        clear_model();
        run_frame("post_rst", 8'h96, 8'h69, 1'b0);
        $display("frame reset abort then tx=96");

        // randomized frames
        for (int i = 0; i < 6; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            lp = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", i), a, b, lp);
            $display("frame rand%0d tx=%0h slave=%0h loop=%0d", i, a, b, lp);
        end

        // single-bit instance: one sclk pulse, cs_n low 3 cycles
        @(negedge clk);
        tx_data1 = 1'b1; tx_valid1 = 1'b1;
        check("w1_ready", 32'(tx_ready1), 32'd1);
        @(negedge clk);
        tx_valid1 = 1'b0;
        check("w1_mosi_setup", 32'(mosi1), 32'd1);
        lo1 = 0; ri1 = 0; rx1_seen = 1'b0; rx1_val = 1'b1; sprev1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (!cs_n1) lo1++;
            if (sclk1 && !sprev1) ri1++;
            if (rx_valid1) begin rx1_seen = 1'b1; rx1_val = rx_data1; end
            sprev1 = sclk1;
            @(negedge clk);
        end
        check("w1_cslow", 32'(lo1), 32'd3);
        check("w1_rises", 32'(ri1), 32'd1);
        check("w1_rxv",   32'(rx1_seen), 32'd1);
        check("w1_rxd",   32'(rx1_val), 32'd0);
        $display("frame width1 tx=1 miso=0");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
